i2s_master_tx: RTL and testbench
================================

// Module: i2s_master_tx
// PURPOSE
//  I2S transmitter (bus master): serializes parallel left/right samples onto I2S_sclk/I2S_ws/I2S_data.
//  Transmit-side counterpart of I2S_Slave; drives the DAC/codec from equalizer output, and is the
//  I2S source for bench loopback into I2S_Slave. Double-buffered, with a sample-request handshake.
// PARAMETERS
//  SCLK_DIV  16  clk cycles per I2S_sclk half-period (>=2); sclk period = 2*SCLK_DIV clk
//  WORD_W    24  sample width in bits (1..31); each channel slot is fixed at 32 sclk
// PORTS
//  clk        in   1       system clock
//  RST_n      in   1       reset, asynchronous, active-low
//  en         in   1       transmit enable
//  lft_in     in   WORD_W  left sample, two's complement
//  rght_in    in   WORD_W  right sample, two's complement
//  wrt        in   1       1-clk strobe: capture lft_in/rght_in into holding regs
//  smpl_req   out  1       1-clk pulse: holding regs consumed, supply next pair
//  underrun   out  1       1-clk pulse: frame started with no fresh pair
//  I2S_sclk   out  1       bit clock
//  I2S_ws     out  1       word select: 0 = left, 1 = right
//  I2S_data   out  1       serial data, MSB first
// BEHAVIOUR
//  Reset (async): I2S_sclk=0, I2S_ws=1, I2S_data=0, smpl_req=0, underrun=0; all counters 0;
//   holding and shift regs 0; fresh=0. All outputs are registered.
//  Clock gen: clk_cnt 0..SCLK_DIV-1; on wrap, sclk toggles. First rising edge comes SCLK_DIV clk
//   after en rises; first falling edge comes 2*SCLK_DIV clk after en rises.
//  All ws/data updates occur on the clk where sclk falls; receiver samples on rising sclk.
//  bit_cnt 0..63 advances on each falling edge; the first fall after en is bit_cnt=0.
//  I2S_ws = (bit_cnt>=32). Slot k = bit_cnt mod 32.
//  Standard I2S one-bit delay: slot 0 = 0; slots 1..WORD_W = sample MSB..LSB; remaining slots = 0.
//  Frame start (fall with bit_cnt=0): shift regs load from holding; smpl_req pulses that clk.
//  If fresh=0 at load: underrun pulses the same clk and the repeat/zero rule applies (CONFIGURATION).
//  fresh is cleared on load.
//  wrt: holding <= inputs, fresh=1. A wrt with fresh=1 overwrites (latest wins, no flag).
//   A wrt on the load clk bypasses: the new pair loads directly and does not count as underrun.
//  Frame period = 64*2*SCLK_DIV clk (2048 at default); smpl_req spacing equals the frame period.
//  en low: counters cleared next clk; sclk=0, ws=1, data=0; no pulses.
//   Holding regs and fresh are kept. en high restarts at bit_cnt=0 on the first falling edge.
//  RST_n asserted mid-frame: immediate return to reset values; the partial frame is abandoned.
// CONFIGURATION
//  I2S_TX_UNDERRUN_ZERO_EN defined: an underrun frame transmits all-zero samples (silence);
//   holding regs are zeroed so later underruns also send silence.
//  Not defined: an underrun frame retransmits the last loaded pair unchanged.
//  underrun pulse timing is identical in both builds.
// TESTING
//  1. Assert RST_n=0 mid-frame -> outputs go immediately to sclk=0, ws=1, data=0, smpl_req=0,
//     underrun=0; after release with en=1, the first sclk fall comes at clk 32 (SCLK_DIV=16).
//  2. wrt lft=24'hA5A5A5, rght=24'h5A5A5A before the first frame -> I2S_Slave loopback captures
//     the same pair; ws toggles every 1024 clk; smpl_req spacing is 2048 clk; underrun stays 0.
//  3. Write nothing for frame 2 -> one underrun pulse coincident with smpl_req; slave receives
//     A5A5A5/5A5A5A again (macro undefined), or 0/0 (I2S_TX_UNDERRUN_ZERO_EN).
//  4. wrt 24'h123456/24'hFEDCBA on the exact smpl_req clk -> no underrun; that pair is sent in
//     the current frame.
//  5. Two wrts within one frame (111111, then 222222) -> only 222222 is transmitted.
//  6. 16 random pairs, each written on smpl_req -> slave vld once per frame, every pair matches
//     in order, underrun never pulses; drop en mid-frame -> sclk held 0 within 1 clk.

Source files
------------

// File: rtl/i2s_master_tx.sv
//-----------------------------------------------------------------------------
// i2s_master_tx
//
// I2S bus-master transmitter. Generates the bit clock and word select itself
// and serializes a double-buffered left/right sample pair, MSB first, with the
// standard one-bit delay after each word-select change. A one-clk smpl_req
// pulse marks the moment the holding registers are consumed. A one-clk
// underrun pulse marks a frame that started with no fresh pair written.
//
// Build option:
//   I2S_TX_UNDERRUN_ZERO_EN  defined     : an underrun frame sends silence, and
//                                          the holding regs are zeroed.
//                            not defined : an underrun frame resends the last
//                                          loaded pair.
//
// Parameters:
//   SCLK_DIV  clk cycles per I2S_sclk half period (>= 2)
//   WORD_W    sample width in bits (1..31); each channel slot is 32 sclk
//
// Ports:
//   clk       system clock
//   RST_n     asynchronous active-low reset
//   en        transmit enable; low clears the bit clock and frame counters
//   lft_in    left sample, two's complement
//   rght_in   right sample, two's complement
//   wrt       1-clk strobe that captures lft_in/rght_in into the holding regs
//   smpl_req  1-clk pulse: holding regs consumed, supply the next pair
//   underrun  1-clk pulse: a frame started without a fresh pair
//   I2S_sclk  bit clock (receiver samples on the rising edge)
//   I2S_ws    word select, 0 = left, 1 = right
//   I2S_data  serial data, MSB first
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module i2s_master_tx #(
    parameter int SCLK_DIV = 16,
    parameter int WORD_W   = 24
) (
    input  logic              clk,
    input  logic              RST_n,
    input  logic              en,
    input  logic [WORD_W-1:0] lft_in,
    input  logic [WORD_W-1:0] rght_in,
    input  logic              wrt,
    output logic              smpl_req,
    output logic              underrun,
    output logic              I2S_sclk,
    output logic              I2S_ws,
    output logic              I2S_data
);

    localparam int               CNT_W     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCLK_DIV - 1);
    localparam logic [4:0]       LAST_SLOT = 5'(WORD_W);

    logic [CNT_W-1:0]  clk_cnt_reg;
    logic [5:0]        bit_cnt_reg;    // index of the bit driven on the next fall
    logic [WORD_W-1:0] hold_l_reg;
    logic [WORD_W-1:0] hold_r_reg;
    logic [WORD_W-1:0] shift_l_reg;
    logic [WORD_W-1:0] shift_r_reg;
    logic              fresh_reg;      // holding regs written since the last load

    logic       wrap;
    logic       fall;
    logic       frame_start;
    logic [4:0] slot;
    logic       in_word;

    // The half-period counter only runs while enabled, so the first rise
    // lands SCLK_DIV clk after en and the first fall 2*SCLK_DIV clk after en.
    assign wrap        = en && (clk_cnt_reg == CNT_LAST);
    assign fall        = wrap && I2S_sclk;
    assign slot        = bit_cnt_reg[4:0];
    assign frame_start = fall && (bit_cnt_reg == 6'd0);
    // Slot 0 of each half is the one-bit I2S delay; sample bits sit in
    // slots 1..WORD_W and the rest of the slot is zero padding.
    assign in_word     = (slot != 5'd0) && (slot <= LAST_SLOT);

    //-------------------------------------------------------------------------
    // Bit clock, frame position, and the serial outputs
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            clk_cnt_reg <= '0;
            bit_cnt_reg <= 6'd0;
            I2S_sclk    <= 1'b0;
            I2S_ws      <= 1'b1;
            I2S_data    <= 1'b0;
        end else if (!en) begin
            clk_cnt_reg <= '0;
            bit_cnt_reg <= 6'd0;
            I2S_sclk    <= 1'b0;
            I2S_ws      <= 1'b1;
            I2S_data    <= 1'b0;
        end else begin
            if (wrap) begin
                clk_cnt_reg <= '0;
                I2S_sclk    <= ~I2S_sclk;
            end else begin
                clk_cnt_reg <= clk_cnt_reg + 1'b1;
            end

            // ws and data only change together with the falling sclk edge.
            if (fall) begin
                bit_cnt_reg <= bit_cnt_reg + 6'd1;
                I2S_ws      <= bit_cnt_reg[5];
                if (in_word) begin
                    I2S_data <= bit_cnt_reg[5] ? shift_r_reg[WORD_W-1]
                                               : shift_l_reg[WORD_W-1];
                end else begin
                    I2S_data <= 1'b0;
                end
            end
        end
    end

    //-------------------------------------------------------------------------
    // Holding regs, shift regs, and the request/underrun handshake
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            hold_l_reg  <= '0;
            hold_r_reg  <= '0;
            shift_l_reg <= '0;
            shift_r_reg <= '0;
            fresh_reg   <= 1'b0;
            smpl_req    <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            smpl_req <= frame_start;
            // A write landing on the load clk counts as fresh data.
            underrun <= frame_start && !wrt && !fresh_reg;

            if (wrt) begin
                hold_l_reg <= lft_in;
                hold_r_reg <= rght_in;
                fresh_reg  <= 1'b1;
            end

            if (frame_start) begin
                // Assignments here win over the capture above, so a write on
                // the load clk leaves fresh clear and is consumed immediately.
                fresh_reg <= 1'b0;
                if (wrt) begin
                    shift_l_reg <= lft_in;
                    shift_r_reg <= rght_in;
                end else if (fresh_reg) begin
                    shift_l_reg <= hold_l_reg;
                    shift_r_reg <= hold_r_reg;
                end else begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
                    shift_l_reg <= '0;
                    shift_r_reg <= '0;
                    hold_l_reg  <= '0;
                    hold_r_reg  <= '0;
`else
                    // Holding still equals the pair loaded last frame.
                    shift_l_reg <= hold_l_reg;
                    shift_r_reg <= hold_r_reg;
`endif
                end
            end else if (fall && in_word) begin
                if (bit_cnt_reg[5]) begin
                    shift_r_reg <= shift_r_reg << 1;
                end else begin
                    shift_l_reg <= shift_l_reg << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_master_tx.sv
//-----------------------------------------------------------------------------
// tb_i2s_master_tx
//
// Drives i2s_master_tx and decodes its serial output with a behavioural I2S
// receiver (word select edge, one-bit delay, MSB first). Expected pairs and
// timings come from the frame rules: a frame is 64 sclk of 2*SCLK_DIV clk,
// each frame carries the most recently written pair, or repeats the previous
// one (silence in the zero build) when nothing was written.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_master_tx;

    localparam int SCLK_DIV = 16;
    localparam int WORD_W   = 24;
    localparam int FRAME    = 64 * 2 * SCLK_DIV;
    localparam int HALF     = FRAME / 2;
    localparam int CLK_NS   = 10;

    logic              clk     = 1'b0;
    logic              RST_n   = 1'b0;
    logic              en      = 1'b0;
    logic              wrt     = 1'b0;
    logic [WORD_W-1:0] lft_in  = '0;
    logic [WORD_W-1:0] rght_in = '0;
    logic              smpl_req;
    logic              underrun;
    logic              I2S_sclk;
    logic              I2S_ws;
    logic              I2S_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // clk-level event logs, written only by the monitor below
    int   req_q[$];
    int   ur_q[$];
    int   ws_q[$];
    logic ws_prev = 1'b1;

    // receiver state and output, written only by the receiver below
    logic              rx_prev_ws = 1'b1;
    int                rx_slot    = 0;
    logic [WORD_W-1:0] rx_sh      = '0;
    logic [WORD_W-1:0] rx_cur_l   = '0;
    logic [WORD_W-1:0] rx_l[$];
    logic [WORD_W-1:0] rx_r[$];
    longint            rx_t[$];
    int                pad_errs   = 0;
    int                rx_rd      = 0;   // read index, used only by the tests

    i2s_master_tx #(.SCLK_DIV(SCLK_DIV), .WORD_W(WORD_W)) dut (
        .clk      (clk),
        .RST_n    (RST_n),
        .en       (en),
        .lft_in   (lft_in),
        .rght_in  (rght_in),
        .wrt      (wrt),
        .smpl_req (smpl_req),
        .underrun (underrun),
        .I2S_sclk (I2S_sclk),
        .I2S_ws   (I2S_ws),
        .I2S_data (I2S_data)
    );

    always #(CLK_NS/2) clk = ~clk;

    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (smpl_req === 1'b1) req_q.push_back(cyc);
        if (underrun === 1'b1) ur_q.push_back(cyc);
        if (I2S_ws !== ws_prev) ws_q.push_back(cyc);
        ws_prev = I2S_ws;
    end

    // Behavioural I2S slave: a ws change marks slot 0 (the delay bit), the
    // next WORD_W bits are the word, everything else must be zero.
    always @(posedge I2S_sclk or negedge en or negedge RST_n) begin
        if (!en || !RST_n) begin
            rx_prev_ws = 1'b1;
            rx_slot    = 0;
        end else begin
            if (I2S_ws !== rx_prev_ws) rx_slot = 0;
            else                       rx_slot = rx_slot + 1;
            rx_prev_ws = I2S_ws;
            if (rx_slot >= 1 && rx_slot <= WORD_W) begin
                rx_sh = {rx_sh[WORD_W-2:0], I2S_data};
                if (rx_slot == WORD_W) begin
                    if (I2S_ws == 1'b0) begin
                        rx_cur_l = rx_sh;
                    end else begin
                        rx_l.push_back(rx_cur_l);
                        rx_r.push_back(rx_sh);
                        rx_t.push_back($time);
                    end
                end
            end else if (I2S_data !== 1'b0) begin
                pad_errs = pad_errs + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output logic [WORD_W-1:0] l, output logic [WORD_W-1:0] r,
                              output longint t);
        int n;
        n = 0;
        l = '0;
        r = '0;
        t = 0;
        while (rx_l.size() <= rx_rd && n < 2 * FRAME + 100) begin
            step();
            n++;
        end
        if (rx_l.size() <= rx_rd) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: no pair received within %0d clk, required one", n);
        end else begin
            l = rx_l[rx_rd];
            r = rx_r[rx_rd];
            t = rx_t[rx_rd];
            rx_rd++;
        end
    endtask

    task automatic write_pair(input logic [WORD_W-1:0] l, input logic [WORD_W-1:0] r);
        lft_in  = l;
        rght_in = r;
        wrt     = 1'b1;
        step();
        wrt     = 1'b0;
    endtask

    //-------------------------------------------------------------------------
    task automatic test_reset();
        string      nm[5] = '{"sclk", "ws", "data", "smpl_req", "underrun"};
        logic [4:0] obs;
        logic [4:0] req;
        logic       prev;
        int         rise_k, fall_k, req_k, ur_k;
        req = 5'b01000;

        RST_n = 1'b0;
        en    = 1'b0;
        repeat (3) step();
        obs = {I2S_sclk, I2S_ws, I2S_data, smpl_req, underrun};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[4-i] !== req[4-i]) begin
                failures++;
                $display("FAIL reset_%s: got %b, expected %b", nm[i], obs[4-i], req[4-i]);
            end
        end

        // run part of a frame, then assert reset between clock edges
        @(posedge clk); #2; RST_n = 1'b1;
        step();
        en = 1'b1;
        repeat (700) @(posedge clk);
        #3; RST_n = 1'b0;
        #1;
        obs = {I2S_sclk, I2S_ws, I2S_data, smpl_req, underrun};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[4-i] !== req[4-i]) begin
                failures++;
                $display("FAIL midreset_%s: got %b, expected %b", nm[i], obs[4-i], req[4-i]);
            end
        end

        // release with en high; count clk edges to the first rise and fall
        @(posedge clk); #2; RST_n = 1'b1;
        prev = 1'b0; rise_k = 0; fall_k = 0; req_k = 0; ur_k = 0;
        for (int k = 1; k <= 100 && fall_k == 0; k++) begin
            step();
            if (!prev && I2S_sclk === 1'b1 && rise_k == 0) rise_k = k;
            if (prev && I2S_sclk === 1'b0) fall_k = k;
            if (smpl_req === 1'b1 && req_k == 0) req_k = k;
            if (underrun === 1'b1 && ur_k == 0) ur_k = k;
            prev = I2S_sclk;
        end
        checks++;
        if (rise_k != SCLK_DIV) begin
            failures++;
            $display("FAIL first_rise: at clk %0d, expected %0d", rise_k, SCLK_DIV);
        end
        checks++;
        if (fall_k != 2 * SCLK_DIV) begin
            failures++;
            $display("FAIL first_fall: at clk %0d, expected %0d", fall_k, 2 * SCLK_DIV);
        end
        checks++;
        if (req_k != 2 * SCLK_DIV) begin
            failures++;
            $display("FAIL first_smpl_req: at clk %0d, expected %0d", req_k, 2 * SCLK_DIV);
        end
        checks++;
        if (ur_k != 2 * SCLK_DIV) begin
            failures++;
            $display("FAIL first_underrun: at clk %0d, expected %0d", ur_k, 2 * SCLK_DIV);
        end
        $display("reset: rise at %0d, fall at %0d", rise_k, fall_k);
        en = 1'b0;
        repeat (5) step();
    endtask

    //-------------------------------------------------------------------------
    int req_base, ur_base, ws_base;

    task automatic test_loopback();
        logic [WORD_W-1:0] l, r;
        longint            t;
        int                e0, got;
        req_base = req_q.size();
        ur_base  = ur_q.size();
        ws_base  = ws_q.size();
        rx_rd    = rx_l.size();
        write_pair(24'hA5A5A5, 24'h5A5A5A);
        en = 1'b1;
        e0 = cyc;
        wait_frame(l, r, t);
        $display("frame1: left=%h right=%h", l, r);
        checks++;
        if (l !== 24'hA5A5A5) begin
            failures++;
            $display("FAIL loop_left: got %h, expected a5a5a5", l);
        end
        checks++;
        if (r !== 24'h5A5A5A) begin
            failures++;
            $display("FAIL loop_right: got %h, expected 5a5a5a", r);
        end
        got = (req_q.size() > req_base) ? req_q[req_base] : -1;
        checks++;
        if (got != e0 + 2 * SCLK_DIV) begin
            failures++;
            $display("FAIL loop_req_time: at cyc %0d, expected %0d", got, e0 + 2 * SCLK_DIV);
        end
        got = (ws_q.size() > ws_base + 1) ? ws_q[ws_base+1] - ws_q[ws_base] : -1;
        checks++;
        if (got != HALF) begin
            failures++;
            $display("FAIL loop_ws_spacing: %0d clk, expected %0d", got, HALF);
        end
        checks++;
        if (ur_q.size() != ur_base) begin
            failures++;
            $display("FAIL loop_underrun: %0d pulses, expected 0", ur_q.size() - ur_base);
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_underrun();
        logic [WORD_W-1:0] l, r, el, er;
        longint            t;
        int                got;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        el = '0;
        er = '0;
`else
        el = 24'hA5A5A5;
        er = 24'h5A5A5A;
`endif
        wait_frame(l, r, t);
        $display("frame2: left=%h right=%h", l, r);
        checks++;
        if (l !== el) begin
            failures++;
            $display("FAIL underrun_left: got %h, expected %h", l, el);
        end
        checks++;
        if (r !== er) begin
            failures++;
            $display("FAIL underrun_right: got %h, expected %h", r, er);
        end
        got = (req_q.size() > req_base + 1) ? req_q[req_base+1] - req_q[req_base] : -1;
        checks++;
        if (got != FRAME) begin
            failures++;
            $display("FAIL req_spacing: %0d clk, expected %0d", got, FRAME);
        end
        checks++;
        if (ur_q.size() != ur_base + 1) begin
            failures++;
            $display("FAIL underrun_count: %0d pulses, expected 1", ur_q.size() - ur_base);
        end
        got = (ur_q.size() > ur_base) ? ur_q[ur_base] : -1;
        checks++;
        if (req_q.size() <= req_base + 1 || got != req_q[req_base+1]) begin
            failures++;
            $display("FAIL underrun_time: at cyc %0d, expected the frame-2 smpl_req clk", got);
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_bypass();
        logic [WORD_W-1:0] l, r;
        longint            t;
        int                last, n_ur;
        logic              sr, ur;
        last = req_q[req_q.size()-1];
        n_ur = ur_q.size();
        while (cyc < last + FRAME - 1) step();
        // wrt is sampled on the same clk edge that loads the frame
        write_pair(24'h123456, 24'hFEDCBA);
        sr = smpl_req;
        ur = underrun;
        checks++;
        if (sr !== 1'b1) begin
            failures++;
            $display("FAIL bypass_req: smpl_req=%b, expected 1", sr);
        end
        checks++;
        if (ur !== 1'b0) begin
            failures++;
            $display("FAIL bypass_underrun: underrun=%b, expected 0", ur);
        end
        wait_frame(l, r, t);
        $display("frame3: left=%h right=%h", l, r);
        checks++;
        if (l !== 24'h123456) begin
            failures++;
            $display("FAIL bypass_left: got %h, expected 123456", l);
        end
        checks++;
        if (r !== 24'hFEDCBA) begin
            failures++;
            $display("FAIL bypass_right: got %h, expected fedcba", r);
        end
        checks++;
        if (ur_q.size() != n_ur) begin
            failures++;
            $display("FAIL bypass_ur_count: %0d pulses, expected 0", ur_q.size() - n_ur);
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_overwrite();
        logic [WORD_W-1:0] l, r;
        longint            t;
        int                n_ur;
        n_ur = ur_q.size();
        write_pair(24'h111111, 24'h111111);
        repeat (10) step();
        write_pair(24'h222222, 24'h222222);
        wait_frame(l, r, t);
        $display("frame4: left=%h right=%h", l, r);
        checks++;
        if (l !== 24'h222222) begin
            failures++;
            $display("FAIL overwrite_left: got %h, expected 222222", l);
        end
        checks++;
        if (r !== 24'h222222) begin
            failures++;
            $display("FAIL overwrite_right: got %h, expected 222222", r);
        end
        checks++;
        if (ur_q.size() != n_ur) begin
            failures++;
            $display("FAIL overwrite_underrun: %0d pulses, expected 0", ur_q.size() - n_ur);
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_random_stream();
        logic [WORD_W-1:0] exp_l[$];
        logic [WORD_W-1:0] exp_r[$];
        logic [WORD_W-1:0] l, r, wl, wr;
        longint            t, t_prev;
        int                n_ur, p0, n;
        n_ur = ur_q.size();
        p0   = pad_errs;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                n = 0;
                while (smpl_req !== 1'b1 && n < FRAME + 100) begin
                    step();
                    n++;
                end
                if (smpl_req !== 1'b1) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_req_timeout: no smpl_req within %0d clk", n);
                end
            end
            wl = WORD_W'($urandom);
            wr = WORD_W'($urandom);
            exp_l.push_back(wl);
            exp_r.push_back(wr);
            write_pair(wl, wr);
        end
        t_prev = 0;
        for (int i = 0; i < 16; i++) begin
            wait_frame(l, r, t);
            $display("stream %0d: sent %h/%h received %h/%h", i, exp_l[i], exp_r[i], l, r);
            checks++;
            if (l !== exp_l[i]) begin
                failures++;
                $display("FAIL stream_left[%0d]: got %h, expected %h", i, l, exp_l[i]);
            end
            checks++;
            if (r !== exp_r[i]) begin
                failures++;
                $display("FAIL stream_right[%0d]: got %h, expected %h", i, r, exp_r[i]);
            end
            if (i > 0) begin
                checks++;
                if (t - t_prev != longint'(FRAME * CLK_NS)) begin
                    failures++;
                    $display("FAIL stream_spacing[%0d]: %0d ns, expected %0d", i, t - t_prev,
                             FRAME * CLK_NS);
                end
            end
            t_prev = t;
        end
        checks++;
        if (ur_q.size() != n_ur) begin
            failures++;
            $display("FAIL stream_underrun: %0d pulses, expected 0", ur_q.size() - n_ur);
        end
        checks++;
        if (pad_errs != p0) begin
            failures++;
            $display("FAIL stream_padding: %0d nonzero pad bits, expected 0", pad_errs - p0);
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_en_drop();
        int n, n_req;
        n = 0;
        while (I2S_sclk !== 1'b1 && n < 4 * SCLK_DIV) begin
            step();
            n++;
        end
        en = 1'b0;
        step();
        $display("en drop: sclk=%b ws=%b data=%b", I2S_sclk, I2S_ws, I2S_data);
        checks++;
        if (I2S_sclk !== 1'b0) begin
            failures++;
            $display("FAIL endrop_sclk: got %b, expected 0", I2S_sclk);
        end
        checks++;
        if (I2S_ws !== 1'b1) begin
            failures++;
            $display("FAIL endrop_ws: got %b, expected 1", I2S_ws);
        end
        checks++;
        if (I2S_data !== 1'b0) begin
            failures++;
            $display("FAIL endrop_data: got %b, expected 0", I2S_data);
        end
        n_req = req_q.size();
        repeat (FRAME + 100) step();
        checks++;
        if (req_q.size() != n_req) begin
            failures++;
            $display("FAIL endrop_pulses: %0d smpl_req while disabled, expected 0",
                     req_q.size() - n_req);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_underrun();
        test_bypass();
        test_overwrite();
        test_random_stream();
        test_en_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
